ahb_arbiter: RTL

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/ahb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB request arbiter: FSM states and counter sizing.
package ahb_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RETIRE} arb_state_e;

  // Timeout counter must be able to hold the value TIMEOUT itself.
  function automatic int tmo_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int TMO_W_DEFAULT = tmo_w(255);

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// starting one past the previous winner.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int RR_MODE = 1
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_winner,
  output logic [NUM_SRC-1:0]         win,
  output logic                       vld
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (RR_MODE != 0) idx = IDX_W'((int'(last_winner) + 1 + k) % NUM_SRC);
      else              idx = IDX_W'(k);
      if (!vld && req[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Multi-source AHB command arbiter: grants one source, drives its command,
// waits for ahb_done or a timeout, then retires for one cycle.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          req,
  input  logic [NUM_SRC-1:0]          write,
  input  logic [NUM_SRC-1:0]          read,
  input  logic [NUM_SRC*ADDR_W-1:0]   addr,
  input  logic [NUM_SRC*DATA_W-1:0]   data,
  input  logic                        ahb_done,
  input  logic [DATA_W-1:0]           ahb_rdata,
  output logic [ADDR_W-1:0]           ahb_addr,
  output logic [DATA_W-1:0]           ahb_data_out,
  output logic                        ahb_write,
  output logic                        ahb_read,
  output logic [NUM_SRC-1:0]          gnt,
  output logic [NUM_SRC-1:0]          done,
  output logic [NUM_SRC-1:0]          err,
  output logic [DATA_W-1:0]           rdata
);

  localparam int TMO_W = tmo_w(TIMEOUT);
  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_e         state, state_n;
  logic [TMO_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   last_winner, last_n, win_idx;
  logic [NUM_SRC-1:0] win;
  logic               pick_vld;
  logic [ADDR_W-1:0]  sel_addr, addr_n;
  logic [DATA_W-1:0]  sel_data, data_n, rdata_n;
  logic               win_wr, win_rd, wr_n, rd_n;
  logic [NUM_SRC-1:0] gnt_n, done_n, err_n;

  rr_pick #(.NUM_SRC(NUM_SRC), .RR_MODE(RR_MODE)) u_pick (
    .req         (req),
    .last_winner (last_winner),
    .win         (win),
    .vld         (pick_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    win_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win[i]) begin
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_data = data[i*DATA_W +: DATA_W];
        win_idx  = IDX_W'(i);
      end
    end
    win_wr = |(write & win);
    win_rd = |(read & win);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_winner;
    addr_n  = ahb_addr;
    data_n  = ahb_data_out;
    wr_n    = ahb_write;
    rd_n    = ahb_read;
    gnt_n   = gnt;
    done_n  = '0;
    err_n   = '0;
    rdata_n = rdata;
    case (state)
      IDLE: if (pick_vld) begin
        state_n = BUSY;
        cnt_n   = '0;
        last_n  = win_idx;
        addr_n  = sel_addr;
        data_n  = sel_data;
        wr_n    = win_wr;
        rd_n    = win_rd & ~win_wr;  // write takes precedence on a conflicting command
        gnt_n   = win;
      end
      BUSY: begin
        // A completion on the final counted cycle still beats the timeout.
        if (ahb_done) begin
          done_n  = gnt;
          rdata_n = ahb_rdata;
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          state_n = RETIRE;
        end else if (cnt == TMO_W'(TIMEOUT - 1)) begin
          err_n   = gnt;
          wr_n    = 1'b0;
          rd_n    = 1'b0;
          state_n = RETIRE;
        end else begin
          cnt_n = cnt + TMO_W'(1);
        end
      end
      RETIRE: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_winner  <= IDX_W'(NUM_SRC - 1);
      ahb_addr     <= '0;
      ahb_data_out <= '0;
      ahb_write    <= 1'b0;
      ahb_read     <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      rdata        <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_winner  <= last_n;
      ahb_addr     <= addr_n;
      ahb_data_out <= data_n;
      ahb_write    <= wr_n;
      ahb_read     <= rd_n;
      gnt          <= gnt_n;
      done         <= done_n;
      err          <= err_n;
      rdata        <= rdata_n;
    end
  end

endmodule
